measurement_sequencer: RTL and testbench

- Drives the trigger/stop inputs of the team's pulse counter: opens a measurement gate of fixed length, then closes it.
- Accumulates the counter's wrap pulses (one per 1000 counts) and snapshots the counter's start and end values.
- Presents a normalised reading (kilo_o × 1000 + units_o) with a one-cycle valid strobe.
- Sits between the control/readout logic and the counter.

---
 rtl/measurement_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_measurement_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/measurement_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : measurement_sequencer
//  Purpose  : Sequences one gated measurement on the pulse counter. It pulses
//             trigger_o, holds the gate open for GATE_CYCLES cycles, pulses
//             stop_o, waits HOLDOFF_CYCLES for the counter to settle, then
//             presents kilo_o*1000 + units_o with a one-cycle valid_o strobe.
//             Wrap pulses from the counter are accumulated as thousands; the
//             start/end counter values are snapshotted to recover the units.
//  Ports    : clk_i, rst_n_i       clock, asynchronous active-low reset
//             start_i              request a measurement (IDLE only)
//             abort_i              cancel measurement in progress
//             continuous_i         re-arm straight after DONE
//             increment_i          counter wrap strobe (count == 1000)
//             pulse_count_i        counter value, 0..1000
//             trigger_o, stop_o    one-cycle gate open / close pulses
//             busy_o, valid_o      not-IDLE flag, result strobe
//             overflow_o           thousands saturated / inconsistent count
//             kilo_o, units_o      held result
//  Revision : 1.0  initial release
// ============================================================================
module measurement_sequencer #(
  parameter int unsigned GATE_CYCLES    = 1000000,
  parameter int unsigned HOLDOFF_CYCLES = 4,
  parameter int unsigned KILO_W         = 12,
  parameter int unsigned GATE_W         = 20
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              continuous_i,
  input  logic              increment_i,
  input  logic [9:0]        pulse_count_i,
  output logic              trigger_o,
  output logic              stop_o,
  output logic              busy_o,
  output logic              valid_o,
  output logic              overflow_o,
  output logic [KILO_W-1:0] kilo_o,
  output logic [9:0]        units_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_GATE  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ABORT = 3'd6;  // single stop pulse after an abort

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [GATE_W-1:0] HOLD_LAST = GATE_W'(HOLDOFF_CYCLES - 1);
  localparam logic [KILO_W-1:0] KILO_MAX  = '1;

  logic [2:0]        state_q, state_d;
  logic [GATE_W-1:0] cnt_q, cnt_d;          // shared by GATE and HOLD
  logic [9:0]        start_units_q, start_units_d;
  logic [KILO_W-1:0] kilo_acc_q, kilo_acc_d;
  logic              sat_q, sat_d;
  logic [KILO_W-1:0] kilo_q, kilo_d;
  logic [9:0]        units_q, units_d;
  logic              ovf_q, ovf_d;

  // Counter value 1000 is the wrap point and is equivalent to 0.
  logic [9:0] cur_units_w;
  logic       borrow_w;
  assign cur_units_w = (pulse_count_i == 10'd1000) ? 10'd0 : pulse_count_i;
  assign borrow_w    = (cur_units_w < start_units_q);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    start_units_d = start_units_q;
    kilo_acc_d    = kilo_acc_q;
    sat_d         = sat_q;
    kilo_d        = kilo_q;
    units_d       = units_q;
    ovf_d         = ovf_q;

    // Wraps are accepted while the counter may still be running or settling.
    if (increment_i && (state_q == S_GATE || state_q == S_STOP || state_q == S_HOLD)) begin
      if (kilo_acc_q == KILO_MAX) begin
        sat_d = 1'b1;
      end else begin
        kilo_acc_d = kilo_acc_q + KILO_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_ARM;
      end
      S_ARM: begin
        start_units_d = cur_units_w;
        kilo_acc_d    = '0;
        sat_d         = 1'b0;
        cnt_d         = '0;
        state_d       = abort_i ? S_ABORT : S_GATE;
      end
      S_GATE: begin
        if (abort_i) begin
          state_d = S_ABORT;
        end else if (cnt_q == GATE_LAST) begin
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + GATE_W'(1);
        end
      end
      S_STOP: begin
        // stop_o is already high this cycle, so an abort skips the extra pulse.
        cnt_d   = '0;
        state_d = abort_i ? S_IDLE : S_HOLD;
      end
      S_HOLD: begin
        if (abort_i) begin
          state_d = S_ABORT;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = S_DONE;
          // Use the post-increment accumulator so a wrap landing on this
          // same cycle (counter reading 1000 -> 0) is not lost.
          if (!borrow_w) begin
            units_d = cur_units_w - start_units_q;
            kilo_d  = kilo_acc_d;
            ovf_d   = sat_d;
          end else if (kilo_acc_d == '0) begin
            units_d = '0;
            kilo_d  = '0;
            ovf_d   = 1'b1;
          end else begin
            // start > end here, so 1000 - start and the sum both stay < 1000.
            units_d = cur_units_w + (10'd1000 - start_units_q);
            kilo_d  = kilo_acc_d - KILO_W'(1);
            ovf_d   = sat_d;
          end
        end else begin
          cnt_d = cnt_q + GATE_W'(1);
        end
      end
      S_DONE: begin
        state_d = continuous_i ? S_ARM : S_IDLE;
      end
      S_ABORT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      start_units_q <= '0;
      kilo_acc_q    <= '0;
      sat_q         <= 1'b0;
      kilo_q        <= '0;
      units_q       <= '0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      start_units_q <= start_units_d;
      kilo_acc_q    <= kilo_acc_d;
      sat_q         <= sat_d;
      kilo_q        <= kilo_d;
      units_q       <= units_d;
      ovf_q         <= ovf_d;
    end
  end

  assign trigger_o  = (state_q == S_ARM);
  assign stop_o     = (state_q == S_STOP) || (state_q == S_ABORT);
  assign busy_o     = (state_q != S_IDLE);
  assign valid_o    = (state_q == S_DONE);
  assign overflow_o = ovf_q;
  assign kilo_o     = kilo_q;
  assign units_o    = units_q;

endmodule
`default_nettype wire

// File: tb/tb_measurement_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_measurement_sequencer
//  Purpose  : Four sequencer instances with different gate/kilo parameters,
//             each driving a small model of the pulse counter. Expected
//             results are queued before each start; a monitor per instance
//             pops and compares whenever valid_o strobes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_measurement_sequencer;

  typedef struct {
    int kilo;
    int units;
    int ovf;
  } exp_t;

  logic clk;
  logic [3:0] rstn_v;
  logic [3:0] start_v;
  logic [3:0] abort_v;
  logic [3:0] cont_v;
  logic [3:0] preload_v;
  logic [9:0] preload_val;

  logic        trig_a  [4];
  logic        stop_a  [4];
  logic        busy_a  [4];
  logic        valid_a [4];
  logic        ovf_a   [4];
  logic [11:0] kilo_a  [4];
  logic [9:0]  units_a [4];

  exp_t exp_q[$];
  int vectors;
  int miscompares;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar i = 0; i < 4; i++) begin : g_inst
    localparam int GC = (i == 0) ? 2499 : (i == 1) ? 599 : (i == 2) ? 9 : 4999;
    localparam int KW = (i == 3) ? 2 : 12;

    logic [KW-1:0] kilo_w;
    logic [9:0]    cnt_q;
    logic          en_q;
    logic          inc_q;
    wire  [9:0]    cnt_nxt = (cnt_q == 10'd1000) ? 10'd1 : cnt_q + 10'd1;

    // Pulse counter model: enabled the cycle after trigger, counts through
    // the stop cycle, holds 1000 for one cycle with a wrap pulse.
    always @(posedge clk or negedge rstn_v[i]) begin
      if (!rstn_v[i]) begin
        cnt_q <= 10'd0;
        en_q  <= 1'b0;
        inc_q <= 1'b0;
      end else begin
        if (trig_a[i]) en_q <= 1'b1;
        else if (stop_a[i]) en_q <= 1'b0;
        if (preload_v[i]) begin
          cnt_q <= preload_val;
          inc_q <= 1'b0;
        end else if (en_q) begin
          cnt_q <= cnt_nxt;
          inc_q <= (cnt_nxt == 10'd1000);
        end else begin
          inc_q <= 1'b0;
        end
      end
    end

    measurement_sequencer #(
      .GATE_CYCLES   (GC),
      .HOLDOFF_CYCLES(4),
      .KILO_W        (KW),
      .GATE_W        (20)
    ) u_dut (
      .clk_i        (clk),
      .rst_n_i      (rstn_v[i]),
      .start_i      (start_v[i]),
      .abort_i      (abort_v[i]),
      .continuous_i (cont_v[i]),
      .increment_i  (inc_q),
      .pulse_count_i(cnt_q),
      .trigger_o    (trig_a[i]),
      .stop_o       (stop_a[i]),
      .busy_o       (busy_a[i]),
      .valid_o      (valid_a[i]),
      .overflow_o   (ovf_a[i]),
      .kilo_o       (kilo_w),
      .units_o      (units_a[i])
    );

    assign kilo_a[i] = 12'(kilo_w);

    exp_t e;
    always @(negedge clk) begin
      if (valid_a[i]) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_valid inst %0d: valid_o=1, required no result", i);
        end else begin
          e = exp_q.pop_front();
          vectors++;
          if (int'(kilo_a[i]) != e.kilo) begin
            miscompares++;
            $display("FAIL kilo inst %0d: got %0d, expected %0d", i, kilo_a[i], e.kilo);
          end
          vectors++;
          if (int'(units_a[i]) != e.units) begin
            miscompares++;
            $display("FAIL units inst %0d: got %0d, expected %0d", i, units_a[i], e.units);
          end
          vectors++;
          if (int'(ovf_a[i]) != e.ovf) begin
            miscompares++;
            $display("FAIL overflow inst %0d: got %0d, expected %0d", i, ovf_a[i], e.ovf);
          end
        end
      end
    end
  end

  function automatic void chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(int k, int u, int o);
    exp_t x;
    x.kilo  = k;
    x.units = u;
    x.ovf   = o;
    exp_q.push_back(x);
  endtask

  task automatic start(int i);
    start_v[i] = 1'b1;
    tick(1);
    start_v[i] = 1'b0;
  endtask

  task automatic wait_idle(int i, int budget, string name);
    int c = 0;
    while (busy_a[i] && c < budget) begin
      tick(1);
      c++;
    end
    chk(name, int'(busy_a[i]), 0);
  endtask

  task automatic wait_valid(int i, int budget, string name);
    int c = 0;
    while (!valid_a[i] && c < budget) begin
      tick(1);
      c++;
    end
    chk(name, int'(valid_a[i]), 1);
  endtask

  task automatic wait_stop(int i, int budget, string name);
    int c = 0;
    while (!stop_a[i] && c < budget) begin
      tick(1);
      c++;
    end
    chk(name, int'(stop_a[i]), 1);
  endtask

  initial begin
    int c;
    vectors     = 0;
    miscompares = 0;
    rstn_v      = 4'h0;
    start_v     = 4'h0;
    abort_v     = 4'h0;
    cont_v      = 4'h0;
    preload_v   = 4'h0;
    preload_val = 10'd0;
    tick(2);

    // Outputs while held in reset
    chk("rst_trigger", int'(trig_a[0]), 0);
    chk("rst_stop", int'(stop_a[0]), 0);
    chk("rst_busy", int'(busy_a[0]), 0);
    chk("rst_valid", int'(valid_a[0]), 0);
    chk("rst_overflow", int'(ovf_a[0]), 0);
    chk("rst_kilo", int'(kilo_a[0]), 0);
    chk("rst_units", int'(units_a[0]), 0);
    rstn_v = 4'hF;
    tick(2);

    // 2500 counts from zero: 2 wraps, 500 units; gate length trigger->stop
    push(2, 500, 0);
    start(0);
    chk("trigger_in_arm", int'(trig_a[0]), 1);
    chk("trigger_stop_exclusive", int'(stop_a[0]), 0);
    c = 0;
    do begin
      tick(1);
      c++;
    end while (!stop_a[0] && c < 3000);
    chk("trigger_to_stop_cycles", c, 2500);
    wait_idle(0, 20, "t1_done_timeout");
    chk("t1_hold_kilo", int'(kilo_a[0]), 2);
    chk("t1_hold_units", int'(units_a[0]), 500);

    // Abort in the middle of GATE
    start(0);
    tick(100);
    abort_v[0] = 1'b1;
    tick(1);
    abort_v[0] = 1'b0;
    chk("abort_stop_pulse", int'(stop_a[0]), 1);
    chk("abort_busy", int'(busy_a[0]), 1);
    chk("abort_no_trigger", int'(trig_a[0]), 0);
    tick(1);
    chk("abort_idle_busy", int'(busy_a[0]), 0);
    chk("abort_single_stop", int'(stop_a[0]), 0);
    chk("abort_kept_kilo", int'(kilo_a[0]), 2);
    chk("abort_kept_units", int'(units_a[0]), 500);
    chk("abort_kept_overflow", int'(ovf_a[0]), 0);
    tick(20);

    // Reset during HOLD, then a clean measurement
    start(0);
    wait_stop(0, 3000, "t6_stop_timeout");
    tick(1);
    chk("t6_in_hold_busy", int'(busy_a[0]), 1);
    rstn_v[0] = 1'b0;
    #1;
    chk("t6_rst_busy", int'(busy_a[0]), 0);
    chk("t6_rst_kilo", int'(kilo_a[0]), 0);
    chk("t6_rst_units", int'(units_a[0]), 0);
    chk("t6_rst_stop", int'(stop_a[0]), 0);
    tick(1);
    rstn_v[0] = 1'b1;
    tick(2);
    push(2, 500, 0);
    start(0);
    wait_idle(0, 3000, "t6_clean_timeout");

    // Borrow: counter left at 700, 600 counts -> end 300, one wrap
    preload_val  = 10'd700;
    preload_v[1] = 1'b1;
    tick(1);
    preload_v[1] = 1'b0;
    push(0, 600, 0);
    start(1);
    wait_idle(1, 1000, "t2_done_timeout");

    // Continuous: back-to-back 10-count measurements, ARM right after DONE
    cont_v[2] = 1'b1;
    push(0, 10, 0);
    push(0, 10, 0);
    push(0, 10, 0);
    start(2);
    wait_valid(2, 40, "t3_valid1_timeout");
    tick(1);
    chk("t3_rearm1", int'(trig_a[2]), 1);
    wait_valid(2, 40, "t3_valid2_timeout");
    tick(1);
    chk("t3_rearm2", int'(trig_a[2]), 1);
    cont_v[2] = 1'b0;
    wait_valid(2, 40, "t3_valid3_timeout");
    tick(1);
    chk("t3_final_idle", int'(busy_a[2]), 0);

    // KILO_W=2: five wraps saturate at 3 with overflow
    push(3, 0, 1);
    start(3);
    wait_idle(3, 6000, "t5_done_timeout");
    chk("t5_hold_overflow", int'(ovf_a[3]), 1);

    tick(5);
    chk("results_outstanding", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
